// File: rtl/wb_reg_slave.sv
// Wishbone classic-cycle slave register bank with programmable wait states,
// byte-select writes, a read-only ID word and error termination.
module wb_reg_slave #(
    parameter int                ADDR_W      = 10,
    parameter int                DATA_W      = 32,
    parameter int                SEL_W       = 4,
    parameter int                NUM_REGS    = 16,
    parameter logic [ADDR_W-1:0] ID_ADDR     = 10'h3FF,
    parameter logic [DATA_W-1:0] ID_VALUE    = 32'hE7A0_0001,
    parameter int                WAIT_CYCLES = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [SEL_W-1:0]  wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [DATA_W-1:0] ctrl_o
);

    localparam int         IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_TERM
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;

    logic [ADDR_W-1:0]   adr_q;
    logic [DATA_W-1:0]   dat_q;
    logic [SEL_W-1:0]    sel_q;
    logic                we_q;

    logic [DATA_W-1:0]   regs [NUM_REGS];

    logic                ack_q, err_q;
    logic [DATA_W-1:0]   rdat_q;

    logic                req;
    logic [ADDR_W-1:0]   txn_adr;
    logic [DATA_W-1:0]   txn_dat;
    logic [SEL_W-1:0]    txn_sel;
    logic                txn_we;
    logic                txn_hit;
    logic                txn_id;
    logic [IDX_W-1:0]    txn_idx;
    logic                commit;

    logic                resp_ack, resp_err;
    logic [DATA_W-1:0]   resp_dat;

    // The response flops are still high in the cycle the master sees the
    // termination, so a strobe held through that cycle is not a new request.
    assign req = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;

    // With zero wait states the commit edge is the sampling edge itself, so
    // the live bus is used in IDLE and the latched copy everywhere else.
    always_comb begin
        if (state_q == S_IDLE) begin
            txn_adr = wb_adr_i;
            txn_dat = wb_dat_i;
            txn_sel = wb_sel_i;
            txn_we  = wb_we_i;
        end else begin
            txn_adr = adr_q;
            txn_dat = dat_q;
            txn_sel = sel_q;
            txn_we  = we_q;
        end
    end

    assign txn_hit = 32'(txn_adr) < 32'(NUM_REGS);
    assign txn_id  = (txn_adr == ID_ADDR);
    assign txn_idx = txn_adr[IDX_W-1:0];

    // NOTE: every signal written in a combinational block gets a default on
    // entry, otherwise any path that skips an assignment infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? S_TERM : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!(wb_cyc_i && wb_stb_i)) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = S_TERM;
                end
            end
            S_TERM:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign commit = (state_d == S_TERM) && (state_q != S_TERM) && txn_we && txn_hit;

    always_comb begin
        resp_ack = 1'b0;
        resp_err = 1'b0;
        resp_dat = '0;
        if (state_q == S_TERM) begin
            if (txn_hit) begin
                resp_ack = 1'b1;
                if (!txn_we) resp_dat = regs[txn_idx];
            end else if (txn_id && !txn_we) begin
                resp_ack = 1'b1;
                resp_dat = ID_VALUE;
            end else begin
                resp_err = 1'b1;
            end
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the values from before the edge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && req) begin
                adr_q <= wb_adr_i;
                dat_q <= wb_dat_i;
                sel_q <= wb_sel_i;
                we_q  <= wb_we_i;
            end
            ack_q  <= resp_ack;
            err_q  <= resp_err;
            rdat_q <= resp_dat;
        end
    end

    // NOTE: this register array is reset because the bank must read back as
    // zero after reset; a true RAM would be left unreset.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit) begin
            for (int k = 0; k < SEL_W; k++) begin
                if (txn_sel[k]) regs[txn_idx][8*k +: 8] <= txn_dat[8*k +: 8];
            end
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = rdat_q;
    assign ctrl_o   = regs[0];

endmodule

// File: tb/tb_wb_reg_slave.sv
// Self-checking bench for wb_reg_slave: three instances (1, 4 and 0 wait states)
// driven by directed and random Wishbone cycles against a word-level model.
module tb_wb_reg_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [9:0]  adr   [3];
    logic [31:0] dat_w [3];
    logic [31:0] dat_r [3];
    logic [31:0] ctrl  [3];
    logic [3:0]  sel   [3];
    logic        we    [3];
    logic        cyc   [3];
    logic        stb   [3];
    logic        ack   [3];
    logic        err   [3];

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [3][16];

    wb_reg_slave #(.WAIT_CYCLES(1)) u0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr[0]), .wb_dat_i(dat_w[0]),
        .wb_dat_o(dat_r[0]), .wb_sel_i(sel[0]), .wb_we_i(we[0]), .wb_cyc_i(cyc[0]),
        .wb_stb_i(stb[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]), .ctrl_o(ctrl[0])
    );

    wb_reg_slave #(.WAIT_CYCLES(4)) u1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr[1]), .wb_dat_i(dat_w[1]),
        .wb_dat_o(dat_r[1]), .wb_sel_i(sel[1]), .wb_we_i(we[1]), .wb_cyc_i(cyc[1]),
        .wb_stb_i(stb[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]), .ctrl_o(ctrl[1])
    );

    wb_reg_slave #(.WAIT_CYCLES(0)) u2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr[2]), .wb_dat_i(dat_w[2]),
        .wb_dat_o(dat_r[2]), .wb_sel_i(sel[2]), .wb_we_i(we[2]), .wb_cyc_i(cyc[2]),
        .wb_stb_i(stb[2]), .wb_ack_o(ack[2]), .wb_err_o(err[2]), .ctrl_o(ctrl[2])
    );

    function automatic int wait_of(input int d);
        case (d)
            0:       return 1;
            1:       return 4;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ack and err must never be high together on any instance
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            assert (!(ack[i] === 1'b1 && err[i] === 1'b1))
            else begin
                errors++;
                $error("FAIL ack_err_excl: instance %0d observed both high expected one", i);
            end
        end
    end

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int r = 0; r < 16; r++) mdl[d][r] = 32'h0;
    endtask

    // Expected termination from the register map rules; updates the model on writes.
    task automatic model_expect(input int d, input bit we_v, input logic [9:0] a,
                                input logic [3:0] s, input logic [31:0] dv,
                                output bit e_ack, output bit e_err, output logic [31:0] e_dat);
        logic [31:0] mask;
        e_ack = 1'b0;
        e_err = 1'b0;
        e_dat = 32'h0;
        if (a < 10'd16) begin
            e_ack = 1'b1;
            if (we_v) begin
                mask = 32'h0;
                for (int k = 0; k < 4; k++) if (s[k]) mask = mask | (32'hFF << (8 * k));
                mdl[d][a[3:0]] = (mdl[d][a[3:0]] & ~mask) | (dv & mask);
            end else begin
                e_dat = mdl[d][a[3:0]];
            end
        end else if (a == 10'h3FF) begin
            if (we_v) e_err = 1'b1;
            else begin
                e_ack = 1'b1;
                e_dat = 32'hE7A0_0001;
            end
        end else begin
            e_err = 1'b1;
        end
    endtask

    // Starts a cycle, scrambles the bus after the sampling edge, and waits for a
    // termination. lat = edges after the sampling edge; -1 if none arrived.
    task automatic bus_cycle(input int d, input bit we_v, input logic [9:0] a,
                             input logic [3:0] s, input logic [31:0] dv,
                             input int abort_after, input int budget,
                             output bit got_ack, output bit got_err,
                             output logic [31:0] got_dat, output int lat);
        @(negedge clk);
        adr[d]   = a;
        dat_w[d] = dv;
        sel[d]   = s;
        we[d]    = we_v;
        cyc[d]   = 1'b1;
        stb[d]   = 1'b1;
        got_ack  = 1'b0;
        got_err  = 1'b0;
        got_dat  = 32'h0;
        lat      = -1;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (ack[d] === 1'b1 || err[d] === 1'b1) begin
                got_ack = ack[d];
                got_err = err[d];
                got_dat = dat_r[d];
                lat     = k;
                break;
            end
            if (k == 0) begin
                adr[d]   = 10'($urandom);
                dat_w[d] = $urandom;
                sel[d]   = 4'($urandom);
                we[d]    = 1'($urandom);
            end
            if (abort_after > 0 && k == abort_after) begin
                cyc[d] = 1'b0;
                stb[d] = 1'b0;
            end
        end
    endtask

    task automatic do_access(input int d, input bit we_v, input logic [9:0] a,
                             input logic [3:0] s, input logic [31:0] dv,
                             input bit hold, input string tag);
        bit          e_ack, e_err, g_ack, g_err;
        logic [31:0] e_dat, g_dat;
        int          lat;
        model_expect(d, we_v, a, s, dv, e_ack, e_err, e_dat);
        bus_cycle(d, we_v, a, s, dv, 0, 40, g_ack, g_err, g_dat, lat);
        check({tag, " latency"}, 32'(lat), 32'(1 + wait_of(d)));
        check({tag, " ack"}, 32'(g_ack), 32'(e_ack));
        check({tag, " err"}, 32'(g_err), 32'(e_err));
        if (!we_v) check({tag, " rdata"}, g_dat, e_dat);
        if (!hold) begin
            cyc[d] = 1'b0;
            stb[d] = 1'b0;
        end
        @(posedge clk);
        #1;
        check({tag, " pulse"}, {30'h0, ack[d], err[d]}, 32'h0);
        check({tag, " dat idle"}, dat_r[d], 32'h0);
        cyc[d] = 1'b0;
        stb[d] = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " no repeat"}, {30'h0, ack[d], err[d]}, 32'h0);
        check({tag, " ctrl"}, ctrl[d], mdl[d][0]);
    endtask

    initial begin
        bit          g_ack, g_err;
        logic [31:0] g_dat;
        int          lat;
        int          d;
        int          pick;
        logic [9:0]  ra;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adr[i] = '0; dat_w[i] = '0; sel[i] = '0; we[i] = 1'b0; cyc[i] = 1'b0; stb[i] = 1'b0;
        end
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset ack/err %0d", i), {30'h0, ack[i], err[i]}, 32'h0);
            check($sformatf("reset dat %0d", i), dat_r[i], 32'h0);
            check($sformatf("reset ctrl %0d", i), ctrl[i], 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Load state that the mid-transaction reset must clear.
        do_access(0, 1'b1, 10'd0, 4'hF, 32'h0BAD_F00D, 1'b0, "pre wr u0");
        do_access(2, 1'b1, 10'd5, 4'hF, 32'hCAFE_0005, 1'b0, "pre wr u2");

        // Reset in the middle of WAIT of a write to register 0.
        @(negedge clk);
        adr[0] = 10'd0; dat_w[0] = 32'hDEAD_BEEF; sel[0] = 4'hF; we[0] = 1'b1;
        cyc[0] = 1'b1; stb[0] = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_model();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("rst midwait no term", {30'h0, ack[0], err[0]}, 32'h0);
        end
        check("rst midwait ctrl", ctrl[0], 32'h0);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_access(0, 1'b0, 10'd0, 4'hF, 32'h0, 1'b0, "rd0 after rst");
        do_access(2, 1'b0, 10'd5, 4'hF, 32'h0, 1'b0, "rd5 after rst");

        // Full-word write and read back, one wait state.
        do_access(0, 1'b1, 10'd3, 4'hF, 32'h1234_5678, 1'b0, "wr3");
        do_access(0, 1'b0, 10'd3, 4'h0, 32'h0, 1'b0, "rd3");

        // Byte lanes.
        do_access(0, 1'b1, 10'd0, 4'hF, 32'hFFFF_FFFF, 1'b0, "wr0 ones");
        do_access(0, 1'b1, 10'd0, 4'b0001, 32'h0000_00AA, 1'b0, "wr0 lane0");
        check("ctrl lane0", ctrl[0], 32'hFFFF_FFAA);
        do_access(0, 1'b1, 10'd0, 4'b0000, 32'h0000_0000, 1'b0, "wr0 sel0");
        check("ctrl sel0", ctrl[0], 32'hFFFF_FFAA);

        // ID register and error terminations.
        do_access(0, 1'b0, 10'h3FF, 4'hF, 32'h0, 1'b0, "rd id");
        do_access(0, 1'b1, 10'h3FF, 4'hF, 32'h1111_2222, 1'b0, "wr id");
        do_access(0, 1'b0, 10'h020, 4'hF, 32'h0, 1'b0, "rd unmapped");
        do_access(0, 1'b1, 10'h020, 4'hF, 32'h3333_4444, 1'b0, "wr unmapped");

        // Master abort during a four-cycle wait.
        bus_cycle(1, 1'b1, 10'd1, 4'hF, 32'h5555_5555, 2, 12, g_ack, g_err, g_dat, lat);
        check("abort ack", 32'(g_ack), 32'h0);
        check("abort err", 32'(g_err), 32'h0);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        do_access(1, 1'b0, 10'd1, 4'hF, 32'h0, 1'b0, "rd1 after abort");

        // Back-to-back with zero wait states, then a strobe held through the ack.
        do_access(2, 1'b1, 10'd2, 4'hF, 32'hA5A5_0F0F, 1'b0, "b2b wr2");
        do_access(2, 1'b0, 10'd2, 4'hF, 32'h0, 1'b0, "b2b rd2");
        do_access(2, 1'b1, 10'd0, 4'hC, 32'h9876_5432, 1'b1, "hold wr0");
        do_access(2, 1'b0, 10'd0, 4'hF, 32'h0, 1'b1, "hold rd0");

        // Random traffic on all instances.
        for (int n = 0; n < 60; n++) begin
            d    = $urandom_range(0, 2);
            pick = $urandom_range(0, 9);
            if (pick < 6)       ra = 10'($urandom_range(0, 15));
            else if (pick < 8)  ra = 10'h3FF;
            else                ra = 10'($urandom_range(16, 1022));
            do_access(d, 1'($urandom), ra, 4'($urandom), $urandom, 1'($urandom),
                      $sformatf("rand%0d u%0d a%03h", n, d, ra));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
